// File: rtl/mask_range_decoder.sv
// Two-stage valid/ready pipeline that turns a bit mask into its lowest/highest set-bit
// indices plus empty and contiguity flags (inverse of the start/end mask generator).
module mask_range_decoder #(
    parameter int  MASK_WIDTH      = 32,
    localparam int MASK_WIDTH_BITS = $clog2(MASK_WIDTH)
) (
    input  logic                       axis_aclk,
    input  logic                       axis_resetn,
    input  logic [MASK_WIDTH-1:0]      in_mask,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [MASK_WIDTH_BITS-1:0] out_start_index,
    output logic [MASK_WIDTH_BITS-1:0] out_end_index,
    output logic                       out_empty,
    output logic                       out_contiguous,
    output logic                       out_valid,
    input  logic                       out_ready
);

    logic [MASK_WIDTH-1:0]      r_s1_mask;
    logic                       r_s1_valid;
    logic                       r_s2_valid;
    logic [MASK_WIDTH_BITS-1:0] r_s2_start;
    logic [MASK_WIDTH_BITS-1:0] r_s2_end;
    logic                       r_s2_empty;
    logic                       r_s2_contig;

    logic                       w_s1_load;
    logic                       w_s2_load;
    logic [MASK_WIDTH_BITS-1:0] w_start;
    logic [MASK_WIDTH_BITS-1:0] w_end;
    logic                       w_empty;
    logic                       w_contig;
    logic [MASK_WIDTH-1:0]      w_lowbit;
    logic [MASK_WIDTH-1:0]      w_sum;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // Lowest set bit wins for start (scan high to low), highest wins for end.
    always_comb begin
        w_start = '0;
        w_end   = '0;
        for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
            if (r_s1_mask[MASK_WIDTH-1-i]) begin
                w_start = MASK_WIDTH_BITS'(MASK_WIDTH - 1 - i);
            end
            if (r_s1_mask[i]) begin
                w_end = MASK_WIDTH_BITS'(i);
            end
        end
    end

    // Adding the isolated lowest bit carries through a single run and clears it;
    // any set bit surviving the AND means a second run exists. Wraps at MASK_WIDTH.
    assign w_empty  = (r_s1_mask == '0);
    assign w_lowbit = r_s1_mask & (~r_s1_mask + MASK_WIDTH'(1));
    assign w_sum    = r_s1_mask + w_lowbit;
    assign w_contig = !w_empty && ((w_sum & r_s1_mask) == '0);

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_mask  <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mask <= in_mask;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_s2_valid  <= 1'b0;
            r_s2_start  <= '0;
            r_s2_end    <= '0;
            r_s2_empty  <= 1'b0;
            r_s2_contig <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_start  <= w_start;
                r_s2_end    <= w_end;
                r_s2_empty  <= w_empty;
                r_s2_contig <= w_contig;
            end
        end
    end

    assign out_valid       = r_s2_valid;
    assign out_start_index = r_s2_start;
    assign out_end_index   = r_s2_end;
    assign out_empty       = r_s2_empty;
    assign out_contiguous  = r_s2_contig;

endmodule

// File: tb/tb_mask_range_decoder.sv
// Bench for mask_range_decoder: directed table, stall/reset sequences and random
// traffic on a 32-bit instance, plus directed vectors on an 8-bit instance.
module tb_mask_range_decoder;

    typedef struct packed {
        logic [31:0] mask;
        logic [4:0]  s;
        logic [4:0]  e;
        logic        empty;
        logic        contig;
    } rec_t;

    logic        clk = 1'b0;
    logic        axis_resetn;
    logic [31:0] in_mask;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  out_start_index;
    logic [4:0]  out_end_index;
    logic        out_empty;
    logic        out_contiguous;
    logic        out_valid;
    logic        out_ready;

    logic [7:0]  in_mask8;
    logic        in_valid8;
    logic        in_ready8;
    logic [2:0]  out_start8;
    logic [2:0]  out_end8;
    logic        out_empty8;
    logic        out_contig8;
    logic        out_valid8;
    logic        out_ready8;

    int   n_cmp = 0;
    int   n_err = 0;
    rec_t sb[$];
    rec_t cur_exp;
    rec_t mon_rec;
    rec_t tbl[8];

    always #5 clk = ~clk;

    mask_range_decoder #(.MASK_WIDTH(32)) u_dut32 (
        .axis_aclk(clk), .axis_resetn(axis_resetn),
        .in_mask(in_mask), .in_valid(in_valid), .in_ready(in_ready),
        .out_start_index(out_start_index), .out_end_index(out_end_index),
        .out_empty(out_empty), .out_contiguous(out_contiguous),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mask_range_decoder #(.MASK_WIDTH(8)) u_dut8 (
        .axis_aclk(clk), .axis_resetn(axis_resetn),
        .in_mask(in_mask8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_start_index(out_start8), .out_end_index(out_end8),
        .out_empty(out_empty8), .out_contiguous(out_contig8),
        .out_valid(out_valid8), .out_ready(out_ready8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] gen(input logic [4:0] s, input logic [4:0] e);
        logic [31:0] g = '0;
        for (int i = 0; i < 32; i++) g[i] = (i >= int'(s)) && (i <= int'(e));
        return g;
    endfunction

    function automatic rec_t model(input logic [31:0] m);
        rec_t r = '0;
        bit   found = 0;
        r.mask  = m;
        r.empty = (m == 0);
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                if (!found) r.s = 5'(i);
                r.e   = 5'(i);
                found = 1;
            end
        end
        r.contig = found && (m == gen(r.s, r.e));
        return r;
    endfunction

    function automatic logic [31:0] rnd_mask();
        logic [4:0] a = 5'($urandom_range(0, 31));
        logic [4:0] b = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 4))
            0: return $urandom();
            1: return (a <= b) ? gen(a, b) : gen(b, a);
            2: return 32'h1 << a;
            3: return 32'h0;
            default: return gen(5'd0, 5'd31) & ~(32'h1 << a);
        endcase
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        if (axis_resetn) begin
            if (in_valid && in_ready) sb.push_back(cur_exp);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got start=%0d end=%0d, required no output",
                             out_start_index, out_end_index);
                end else begin
                    mon_rec = sb.pop_front();
                    chk("result", {out_start_index, out_end_index, out_empty, out_contiguous},
                        {mon_rec.s, mon_rec.e, mon_rec.empty, mon_rec.contig});
                    if (out_contiguous)
                        chk("roundtrip", gen(out_start_index, out_end_index), mon_rec.mask);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic drain(input string name);
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_drained"}, 64'(sb.size()), 64'd0);
        chk({name, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [11:0] snap;
        logic [31:0] smask[3];
        logic [7:0]  m8v[4];
        logic [7:0]  e8v[4];
        bit          fired;
        int          acc;
        int          cyc;

        tbl[0] = '{32'h000000F0, 5'd4,  5'd7,  1'b0, 1'b1};
        tbl[1] = '{32'h80000001, 5'd0,  5'd31, 1'b0, 1'b0};
        tbl[2] = '{32'h00000000, 5'd0,  5'd0,  1'b1, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 5'd0,  5'd31, 1'b0, 1'b1};
        tbl[4] = '{32'h00000400, 5'd10, 5'd10, 1'b0, 1'b1};
        tbl[5] = '{32'h80000000, 5'd31, 5'd31, 1'b0, 1'b1};
        tbl[6] = '{32'h00FF0F00, 5'd8,  5'd23, 1'b0, 1'b0};
        tbl[7] = '{32'h7FFFFFFE, 5'd1,  5'd30, 1'b0, 1'b1};

        axis_resetn = 1'b0;
        in_valid = 1'b0; in_mask = '0; out_ready = 1'b1; cur_exp = '0;
        in_valid8 = 1'b0; in_mask8 = '0; out_ready8 = 1'b1;
        #3;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_outputs", {out_start_index, out_end_index, out_empty, out_contiguous}, 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        axis_resetn = 1'b1;

        // Latency: accepted on one edge, valid after the following edge.
        in_valid = 1'b1; in_mask = tbl[0].mask; cur_exp = tbl[0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_not_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_valid", 64'(out_valid), 64'd1);
        drain("latency");

        // Back-to-back table vectors with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_mask = tbl[i].mask; cur_exp = tbl[i];
            fired = 0;
            for (int k = 0; k < 20 && !fired; k++) begin
                @(negedge clk);
                fired = in_ready;
                @(posedge clk); #1;
            end
            chk("table_accept", 64'(fired), 64'd1);
        end
        drain("table");

        // Stall: two accepted, third refused, outputs frozen, then drain in order.
        smask[0] = 32'h0000FF00; smask[1] = 32'h00010001; smask[2] = 32'h7FFFFFFE;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mask = smask[i]; cur_exp = model(smask[i]);
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), (i < 2) ? 64'd1 : 64'd0);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        snap = {out_start_index, out_end_index, out_empty, out_contiguous};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_hold", {out_valid, in_ready, out_start_index, out_end_index,
                               out_empty, out_contiguous}, {2'b10, snap});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_accept_and_consume", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        drain("stall");

        // Random traffic with random backpressure.
        acc = 0; cyc = 0; fired = 0; in_valid = 1'b0;
        while (acc < 10000 && cyc < 60000) begin
            if (fired || !in_valid) begin
                if ($urandom_range(0, 9) < 7) begin
                    in_valid = 1'b1; in_mask = rnd_mask(); cur_exp = model(in_mask);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            fired = in_valid && in_ready;
            if (fired) acc++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("random_transfers", 64'(acc), 64'd10000);
        drain("random");

        // Reset with both stages full discards everything in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_mask = 32'h00F00000 >> i; cur_exp = model(in_mask);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 axis_resetn = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(posedge clk); #1;
        axis_resetn = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_mask = 32'h00000003; cur_exp = model(32'h00000003);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_no_stale", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("rst_first_result", {out_valid, out_start_index, out_end_index, out_empty, out_contiguous},
            {1'b1, 5'd0, 5'd1, 1'b0, 1'b1});
        drain("post_reset");

        // 8-bit instance; expected {start, end, empty, contig}.
        m8v[0] = 8'hA0; e8v[0] = {3'd5, 3'd7, 1'b0, 1'b0};
        m8v[1] = 8'h80; e8v[1] = {3'd7, 3'd7, 1'b0, 1'b1};
        m8v[2] = 8'h00; e8v[2] = {3'd0, 3'd0, 1'b1, 1'b0};
        m8v[3] = 8'hFF; e8v[3] = {3'd0, 3'd7, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            in_valid8 = 1'b1; in_mask8 = m8v[i];
            @(posedge clk); #1;
            in_valid8 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            chk("w8_result", {out_valid8, out_start8, out_end8, out_empty8, out_contig8},
                {1'b1, e8v[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
